// File: rtl/score_tally.sv
// Per-frame hit/miss tally for the dropper lanes: BCD score, combo, max combo, hit/miss counts, game_over.
// Define COMBO_BONUS_EN to score hits that reach BONUS_TH in the running combo at 2 points instead of 1.
module score_tally #(
  parameter int NUM_LANES = 6,
  parameter int ARROW_H   = 40,
  parameter int Y_MAX     = 400,
  parameter int BONUS_TH  = 10
) (
  input  logic                    frame_clk,
  input  logic                    Reset,
  input  logic [7:0]              keycode,
  input  logic [NUM_LANES-1:0]    score_in,
  input  logic [NUM_LANES*10-1:0] drop_y,
  output logic [15:0]             score_bcd,
  output logic [7:0]              combo,
  output logic [7:0]              max_combo,
  output logic [7:0]              hit_cnt,
  output logic [7:0]              miss_cnt,
  output logic                    game_over
);

  localparam logic [7:0] KEY_START   = 8'h2C;
  localparam logic [7:0] KEY_RESTART = 8'h01;

  if (NUM_LANES < 1 || NUM_LANES > 8 || BONUS_TH < 1) begin : g_bad_params
    $error("score_tally: NUM_LANES must be 1..8 and BONUS_TH >= 1");
  end

  typedef enum logic [1:0] {
    IDLE,
    PLAY,
    DONE
  } state_t;

  state_t               state_q, state_d;
  logic [NUM_LANES-1:0] resolved_q, resolved_d;
  logic [NUM_LANES-1:0] prev_q, prev_d;
  logic [15:0]          score_q, score_d;
  logic [7:0]           combo_q, combo_d;
  logic [7:0]           max_q, max_d;
  logic [7:0]           hit_q, hit_d;
  logic [7:0]           miss_q, miss_d;
  logic                 over_q, over_d;

  logic [NUM_LANES-1:0] hit_v;
  logic [NUM_LANES-1:0] miss_v;
  logic [3:0]           h_cnt;
  logic [3:0]           m_cnt;
  logic [4:0]           pts;

  // Bottom edge is computed in 11 bits so a Y near 1023 cannot wrap below Y_MAX.
  for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
    logic [10:0] bottom;
    logic        live;
    assign bottom      = {1'b0, drop_y[10*gi +: 10]} + 11'(ARROW_H);
    assign live        = (state_q == PLAY) && !resolved_q[gi];
    assign hit_v[gi]   = live && score_in[gi] && !prev_q[gi];
    assign miss_v[gi]  = live && !score_in[gi] && (bottom >= 11'(Y_MAX));
  end

  always_comb begin
    h_cnt = '0;
    m_cnt = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      h_cnt = h_cnt + 4'(hit_v[i]);
      m_cnt = m_cnt + 4'(miss_v[i]);
    end
  end

`ifdef COMBO_BONUS_EN
  logic [9:0] bonus_run;

  // Running combo ignores this frame's misses: bonus follows lane order of the hits alone.
  always_comb begin
    pts       = '0;
    bonus_run = {2'b00, combo_q};
    for (int i = 0; i < NUM_LANES; i++) begin
      if (hit_v[i]) begin
        bonus_run = bonus_run + 10'd1;
        pts       = pts + ((int'(bonus_run) >= BONUS_TH) ? 5'd2 : 5'd1);
      end
    end
  end
`else
  assign pts = {1'b0, h_cnt};
`endif

  // Ripple BCD adder; each digit's carry is 0..2 because the ones digit can take up to 16 points.
  logic [9:0]  bcd_cy;
  logic [15:0] bcd_sum;

  for (genvar gi = 0; gi < 4; gi++) begin : g_bcd
    logic [4:0] addend;
    logic [5:0] dsum;
    if (gi == 0) begin : g_ones
      assign addend = pts;
    end else begin : g_upper
      assign addend = {3'b000, bcd_cy[2*gi-1 -: 2]};
    end
    assign dsum = {2'b00, score_q[4*gi +: 4]} + {1'b0, addend};
    assign bcd_cy[2*gi +: 2] = (dsum >= 6'd20) ? 2'd2 : (dsum >= 6'd10) ? 2'd1 : 2'd0;
    // Subtracting 20 or 10 modulo 16 is -4 or +6 on the low nibble.
    assign bcd_sum[4*gi +: 4] = (dsum >= 6'd20) ? (dsum[3:0] - 4'd4) :
                                (dsum >= 6'd10) ? (dsum[3:0] + 4'd6) : dsum[3:0];
  end

  logic [8:0] hit_sum, miss_sum, combo_sum;
  logic [7:0] c1;

  assign hit_sum   = {1'b0, hit_q} + 9'(h_cnt);
  assign miss_sum  = {1'b0, miss_q} + 9'(m_cnt);
  assign combo_sum = {1'b0, combo_q} + 9'(h_cnt);
  assign c1        = combo_sum[8] ? 8'hFF : combo_sum[7:0];

  always_comb begin
    state_d    = state_q;
    resolved_d = resolved_q;
    prev_d     = prev_q;
    score_d    = score_q;
    combo_d    = combo_q;
    max_d      = max_q;
    hit_d      = hit_q;
    miss_d     = miss_q;
    over_d     = over_q;

    unique case (state_q)
      IDLE: begin
        resolved_d = '0;
        prev_d     = '0;
        score_d    = '0;
        combo_d    = '0;
        max_d      = '0;
        hit_d      = '0;
        miss_d     = '0;
        over_d     = 1'b0;
        if (keycode == KEY_START) begin
          state_d = PLAY;
        end
      end
      PLAY: begin
        resolved_d = resolved_q | hit_v | miss_v;
        prev_d     = score_in;
        hit_d      = hit_sum[8] ? 8'hFF : hit_sum[7:0];
        miss_d     = miss_sum[8] ? 8'hFF : miss_sum[7:0];
        max_d      = (c1 > max_q) ? c1 : max_q;
        combo_d    = (m_cnt != 4'd0) ? 8'd0 : c1;
        score_d    = (bcd_cy[7:6] != 2'd0) ? 16'h9999 : bcd_sum;
        if (&resolved_d) begin
          state_d = DONE;
          over_d  = 1'b1;
        end
      end
      DONE: begin
        if (keycode == KEY_RESTART) begin
          state_d    = IDLE;
          resolved_d = '0;
          prev_d     = '0;
          score_d    = '0;
          combo_d    = '0;
          max_d      = '0;
          hit_d      = '0;
          miss_d     = '0;
          over_d     = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      state_q    <= IDLE;
      resolved_q <= '0;
      prev_q     <= '0;
      score_q    <= '0;
      combo_q    <= '0;
      max_q      <= '0;
      hit_q      <= '0;
      miss_q     <= '0;
      over_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      resolved_q <= resolved_d;
      prev_q     <= prev_d;
      score_q    <= score_d;
      combo_q    <= combo_d;
      max_q      <= max_d;
      hit_q      <= hit_d;
      miss_q     <= miss_d;
      over_q     <= over_d;
    end
  end

  assign score_bcd = score_q;
  assign combo     = combo_q;
  assign max_combo = max_q;
  assign hit_cnt   = hit_q;
  assign miss_cnt  = miss_q;
  assign game_over = over_q;

endmodule
